alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one ALU instance between NUM_REQ requesters, e.g. the main execute
//  path and the branch/address unit. Uses round-robin arbitration.
//  Operands are latched on grant, executed in the next cycle, and the result
//  is returned to the granted requester over a valid/ready handshake.
//  Sits between the requesting pipeline stages and the single ALU datapath.
// PARAMETERS
//  NUM_REQ  2   number of requesters (2..8)
//  IDX_W    1   width of grant index, = clog2(NUM_REQ); ports use max(IDX_W,1)
// PORTS
//  clk          in   1            rising-edge clock, sole clock domain
//  rst_n        in   1            asynchronous active-low reset
//  req_valid    in   NUM_REQ      per-requester operation request
//  req_ready    out  NUM_REQ      one-hot accept, combinational, only in IDLE
//  req_srcA     in   32*NUM_REQ   operand A, requester i at [32*i +: 32]
//  req_srcB     in   32*NUM_REQ   operand B, same packing
//  req_ctrl     in   3*NUM_REQ    ALUControl code, requester i at [3*i +: 3]
//  resp_valid   out  NUM_REQ      one-hot: result ready for owner
//  resp_ready   in   NUM_REQ      owner consumes result
//  resp_result  out  32           registered ALU result, shared by all requesters
//  resp_zero    out  1            registered Zero flag
//  resp_illegal out  1            ctrl code was 100/110/111 (result forced 0)
//  busy         out  1            FSM not in IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): FSM=IDLE, rr_ptr=0.
//    req_ready=0, resp_valid=0, resp_result=0, resp_zero=0, resp_illegal=0, busy=0.
//  - FSM states: IDLE -> EXEC -> RESP -> IDLE. No other transitions.
//  - IDLE:
//    - Winner = first i with req_valid[i], searching from rr_ptr upward and
//      wrapping at NUM_REQ.
//    - req_ready[winner]=1 in the same cycle.
//    - On that edge, latch srcA/srcB/ctrl and owner=winner, then go to EXEC.
//    - No valid request: stay in IDLE, req_ready=0.
//  - EXEC:
//    - ALU is driven from the latched operands only.
//    - At cycle end, capture ALUResult, Zero and illegal into the resp regs.
//    - Go to RESP.
//  - RESP:
//    - resp_valid[owner]=1 and held with stable data until resp_ready[owner]=1.
//    - resp_ready on non-owner bits is ignored.
//    - On handshake: rr_ptr = (owner+1) mod NUM_REQ, then go to IDLE.
//  - Latency: accept edge at T, resp_valid high in cycle T+2. Peak rate is
//    one op per 3 cycles. A back-to-back request from the same requester
//    is accepted in the first IDLE cycle after the handshake.
//  - ALU codes:
//    - 000 add, 001 sub, 010 and, 011 or, 101 signed-less-than? No: UNSIGNED
//      compare, matching the ALU's (<) on unsigned operands.
//    - Any other code gives result 0, Zero=1 and resp_illegal=1.
//  - Arithmetic is 32-bit modulo 2^32; no overflow output.
//  - req_valid dropped while in EXEC/RESP has no effect; the operation
//    already runs on latched data.
//  - Requester inputs are never sampled outside IDLE.
//  - Simultaneous requests: round-robin guarantees each requester is granted
//    within NUM_REQ grants.
//  - Async reset mid-operation: an in-flight op is discarded and no response
//    is issued. Requesters must re-issue.
//  - resp_result/zero/illegal keep their last values while in IDLE.
// STRUCTURE
//  - Shared package alu_pkg holds:
//    - ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011,
//      ALU_SLT=3'b101
//    - state encoding ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2
//  - One sub-module: rr_arbiter (NUM_REQ), a combinational one-hot grant
//    from req_valid and rr_ptr.
//  - The existing ALU module is instantiated once inside alu_arbiter.
// TESTING
//  1 Reset: rst_n=0 with req_valid=2'b11 -> req_ready=0, resp_valid=0,
//    resp_result=0, busy=0.
//  2 Single op: req0 add 5+7 accepted at T -> resp_valid=2'b01 at T+2,
//    resp_result=12, zero=0; hold resp_ready=0 for 4 cycles -> data stable.
//  3 Contention: both requesters continuously valid, req0 sub 9-9 and
//    req1 or 0xF0|0x0F -> grants alternate 0,1,0,1.
//    req0 returns result=0 with zero=1; req1 returns 0xFF.
//  4 Illegal and SLT: ctrl=3'b111 -> result 0, zero=1, illegal=1.
//    ctrl=101 with 3,4 -> result 1; with 4,3 -> result 0.
//  5 Reset mid-op: drop rst_n during EXEC -> no resp_valid ever;
//    after release, FSM is IDLE and rr_ptr=0 (req0 wins a tie).
//  6 Wrong-owner ready: in RESP for req1, pulse resp_ready[0] ->
//    FSM stays in RESP and resp_valid[1] stays 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: operation codes, FSM states,
// and the legality check for control codes.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_illegal(input logic [2:0] ctrl);
        return !(ctrl inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT});
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle 32-bit ALU; unsupported codes yield result 0 and flag illegal.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [2:0]  ctrl,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegal
);

    always_comb begin
        result  = 32'd0;
        illegal = is_illegal(ctrl);
        case (ctrl)
            ALU_ADD: result = srcA + srcB;
            ALU_SUB: result = srcA - srcB;
            ALU_AND: result = srcA & srcB;
            ALU_OR:  result = srcA | srcB;
            // Unsigned compare
            ALU_SLT: result = {31'd0, (srcA < srcB)};
            default: result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or above rr_ptr,
// wrapping at NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx[IW-1:0]]) begin
                found                 = 1'b1;
                grant[idx[IW-1:0]]    = 1'b1;
                grant_idx             = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters: grant in IDLE, execute on latched
// operands, then hold a one-hot response until the owner accepts it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [32*NUM_REQ-1:0] req_srcA,
    input  logic [32*NUM_REQ-1:0] req_srcB,
    input  logic [3*NUM_REQ-1:0] req_ctrl,
    output logic [NUM_REQ-1:0]   resp_valid,
    input  logic [NUM_REQ-1:0]   resp_ready,
    output logic [31:0]          resp_result,
    output logic                 resp_zero,
    output logic                 resp_illegal,
    output logic                 busy
);

    localparam int IW = (IDX_W > 1) ? IDX_W : 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    state_t       state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [31:0]  op_a;
    logic [31:0]  op_b;
    logic [2:0]   op_ctrl;

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;
    logic [2:0]         sel_ctrl;
    logic [31:0]        alu_result;
    logic               alu_zero;
    logic               alu_illegal;
    logic               idle_live;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    alu u_alu (
        .srcA    (op_a),
        .srcB    (op_b),
        .ctrl    (op_ctrl),
        .result  (alu_result),
        .zero    (alu_zero),
        .illegal (alu_illegal)
    );

    // No accept is offered while reset is asserted
    assign idle_live = (state == ST_IDLE) && rst_n;
    assign req_ready = idle_live ? grant : '0;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a    = req_srcA[32*i +: 32];
                sel_b    = req_srcB[32*i +: 32];
                sel_ctrl = req_ctrl[3*i +: 3];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            op_a         <= '0;
            op_b         <= '0;
            op_ctrl      <= '0;
            resp_valid   <= '0;
            resp_result  <= '0;
            resp_zero    <= 1'b0;
            resp_illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                        op_ctrl <= sel_ctrl;
                        owner   <= grant_idx;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_result  <= alu_result;
                    resp_zero    <= alu_zero;
                    resp_illegal <= alu_illegal;
                    resp_valid   <= ONE << owner;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready[owner]) begin
                        resp_valid <= '0;
                        rr_ptr     <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized transactions against a transaction-level model of
// round-robin arbitration and ALU arithmetic.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [32*N-1:0] req_srcA = '0;
    logic [32*N-1:0] req_srcB = '0;
    logic [3*N-1:0] req_ctrl = '0;
    logic [N-1:0]  resp_valid;
    logic [N-1:0]  resp_ready = '0;
    logic [31:0]   resp_result;
    logic          resp_zero;
    logic          resp_illegal;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int m_ptr = 0;
    int last_win = -1;

    alu_arbiter #(
        .NUM_REQ (N),
        .IDX_W   (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_srcA     (req_srcA),
        .req_srcB     (req_srcB),
        .req_ctrl     (req_ctrl),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .resp_zero    (resp_zero),
        .resp_illegal (resp_illegal),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {illegal, zero, result}
    function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] c);
        logic [31:0] r;
        logic        ill;
        ill = 1'b0;
        case (int'(c))
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            5: r = (a < b) ? 32'd1 : 32'd0;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
        return {ill, (r == 32'd0), r};
    endfunction

    task automatic scramble_inputs();
        logic [31:0] t;
        t = $urandom;
        req_valid = t[N-1:0];
        req_srcA  = {$urandom, $urandom};
        req_srcB  = {$urandom, $urandom};
        t = $urandom;
        req_ctrl  = t[3*N-1:0];
    endtask

    // Entered just after a negedge with the DUT idle; returns the same way.
    task automatic do_txn(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                          input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c0,
                          input logic [2:0] c1, input int hold, input logic poke_other);
        logic [33:0] exp;
        logic [1:0]  oh;
        logic [31:0] t;
        int          win;
        req_valid  = v;
        req_srcA   = {a1, a0};
        req_srcB   = {b1, b0};
        req_ctrl   = {c1, c0};
        resp_ready = '0;
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        win = -1;
        for (int k = 0; k < N; k++) begin
            if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        end
        last_win = win;
        if (win < 0) begin
            check("no_grant", 32'(req_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("stay_idle", 32'(busy), 32'd0);
            return;
        end
        oh  = 2'b01 << win;
        exp = (win == 0) ? alu_ref(a0, b0, c0) : alu_ref(a1, b1, c1);
        check("grant", 32'(req_ready), 32'(oh));
        @(posedge clk);
        @(negedge clk);
        scramble_inputs();
        #1;
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_ready", 32'(req_ready), 32'd0);
        check("exec_noresp", 32'(resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("resp_valid", 32'(resp_valid), 32'(oh));
        check("resp_result", resp_result, exp[31:0]);
        check("resp_zero", 32'(resp_zero), 32'(exp[32]));
        check("resp_illegal", 32'(resp_illegal), 32'(exp[33]));
        for (int h = 0; h < hold; h++) begin
            t = $urandom;
            resp_ready = poke_other ? ~oh : (t[1:0] & ~oh);
            scramble_inputs();
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(resp_valid), 32'(oh));
            check("hold_result", resp_result, exp[31:0]);
            check("hold_busy", 32'(busy), 32'd1);
        end
        t = $urandom;
        resp_ready = oh | (t[1:0] & ~oh);
        @(posedge clk);
        @(negedge clk);
        resp_ready = '0;
        req_valid  = '0;
        check("done_valid", 32'(resp_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_keep", resp_result, exp[31:0]);
        m_ptr = (win + 1) % N;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b11;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rvalid", 32'(resp_valid), 32'd0);
        check("rst_result", resp_result, 32'd0);
        check("rst_zero", 32'(resp_zero), 32'd0);
        check("rst_illegal", 32'(resp_illegal), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        m_ptr     = 0;
    endtask

    initial begin
        logic [31:0] t;
        logic [1:0]  rv;

        // Reset with both requesters asserting
        apply_reset();

        // Single add with a long hold
        do_txn(2'b01, 32'd5, 32'd7, 32'd0, 32'd0, ALU_ADD, ALU_ADD, 4, 1'b0);
        check("add_12", resp_result, 32'd12);
        check("add_nz", 32'(resp_zero), 32'd0);

        // Contention from a fresh pointer alternates 0,1,0,1
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            do_txn(2'b11, 32'd9, 32'd9, 32'hF0, 32'h0F, ALU_SUB, ALU_OR, 1, 1'b0);
            check("rr_alt", 32'(last_win), 32'(i % 2));
            check("cont_result", resp_result, (i % 2 == 1) ? 32'hFF : 32'h0);
            check("cont_zero", 32'(resp_zero), (i % 2 == 1) ? 32'd0 : 32'd1);
        end

        // Illegal code and unsigned compare
        do_txn(2'b01, 32'h1234, 32'h5678, 32'd0, 32'd0, 3'b111, ALU_ADD, 0, 1'b0);
        check("ill_result", resp_result, 32'd0);
        check("ill_zero", 32'(resp_zero), 32'd1);
        check("ill_flag", 32'(resp_illegal), 32'd1);
        do_txn(2'b10, 32'd0, 32'd0, 32'd3, 32'd4, ALU_ADD, ALU_SLT, 0, 1'b0);
        check("slt_lt", resp_result, 32'd1);
        check("slt_legal", 32'(resp_illegal), 32'd0);
        do_txn(2'b01, 32'd4, 32'd3, 32'd0, 32'd0, ALU_SLT, ALU_ADD, 0, 1'b0);
        check("slt_ge", resp_result, 32'd0);
        do_txn(2'b01, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, ALU_SLT, ALU_ADD, 0, 1'b0);
        check("slt_unsigned", resp_result, 32'd0);

        // Wrong-owner ready while requester 1 owns the response
        do_txn(2'b10, 32'd0, 32'd0, 32'd100, 32'd1, ALU_ADD, ALU_SUB, 3, 1'b1);
        check("wrong_owner", resp_result, 32'd99);

        // Reset during EXEC discards the operation
        req_valid = 2'b10;
        req_srcA  = {32'd1, 32'd1};
        req_srcB  = {32'd1, 32'd1};
        req_ctrl  = {ALU_ADD, ALU_ADD};
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        check("midrst_rvalid", 32'(resp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_none", 32'(resp_valid), 32'd0);
            check("midrst_idle", 32'(busy), 32'd0);
        end
        do_txn(2'b11, 32'd2, 32'd3, 32'd4, 32'd5, ALU_ADD, ALU_ADD, 0, 1'b0);
        check("midrst_tie", 32'(last_win), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            t  = $urandom;
            rv = t[1:0];
            do_txn(rv,
                   t[2] ? $urandom : $urandom_range(0, 8), t[3] ? $urandom : $urandom_range(0, 8),
                   t[4] ? $urandom : $urandom_range(0, 8), t[5] ? $urandom : $urandom_range(0, 8),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
